// File: rtl/cla4_nibble_sequencer.sv
// Nibble-serial WIDTH-bit add/sub controller driving one external combinational CLA4.
// Optional subtract support is enabled by defining CLA4_SEQ_SUB_EN.
module cla4_nibble_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [3:0]       cla_a,
    output logic [3:0]       cla_b,
    output logic             cla_cin,
    input  logic [3:0]       cla_s,
    input  logic             cla_cout,
    output logic [1:0]       dbg_state
);

    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIB - 1);

    // Handshake: start is sampled on a rising edge only while the FSM is in IDLE
    // or DONE; done is high for exactly one cycle and sum/cout/ovf are valid then.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             sub_req;

`ifdef CLA4_SEQ_SUB_EN
    assign sub_req = op_sub;
`else
    logic unused_op_sub;
    assign unused_op_sub = op_sub;
    assign sub_req       = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        cla_a   = 4'd0;
        cla_b   = 4'd0;
        cla_cin = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    // Subtraction is a + ~b + 1: invert B once here, seed carry with 1.
                    a_d     = a;
                    b_d     = sub_req ? ~b : b;
                    carry_d = sub_req;
                    idx_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                cla_a   = a_q[4*idx_q +: 4];
                cla_b   = b_q[4*idx_q +: 4];
                cla_cin = carry_q;
                sum_d[4*idx_q +: 4] = cla_s;
                carry_d = cla_cout;
                if (idx_q == LAST_IDX) begin
                    // cla_s[3] is the result MSB on the final nibble.
                    cout_d  = cla_cout;
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (cla_s[3] != a_q[WIDTH-1]);
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign dbg_state = state_q;

endmodule
